// File: rtl/wave_deserializer_pkg.sv
// Shared constants and types for the waveform deserializer and its generator.
// WD_WIDTH/WD_DEPTH match the generator's 8:1 mux and 16-entry pattern memory;
// WD_EVEN_WORD doubles as the sync word the receiver hunts for.
package wave_deserializer_pkg;

  localparam int         WD_WIDTH      = 8;
  localparam int         WD_DEPTH      = 16;
  localparam logic [7:0] WD_EVEN_WORD  = 8'hCC;
  localparam logic [7:0] WD_ODD_WORD   = 8'hAA;
  localparam int         WD_MISS_LIMIT = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } wd_state_t;

endpackage

// File: rtl/wave_deserializer_if.sv
// Serial-in / word-out bundle between a waveform source and the deserializer.
//   master : drives bit_en, waveform; observes the word-level results
//   slave  : samples bit_en, waveform; drives byte_out, byte_valid, word_idx,
//            locked, frame_done, err_count
interface wave_deserializer_if #(
  parameter int WIDTH = wave_deserializer_pkg::WD_WIDTH,
  parameter int DEPTH = wave_deserializer_pkg::WD_DEPTH
);

  logic                     bit_en;
  logic                     waveform;
  logic [WIDTH-1:0]         byte_out;
  logic                     byte_valid;
  logic [$clog2(DEPTH)-1:0] word_idx;
  logic                     locked;
  logic                     frame_done;
  logic [7:0]               err_count;

  modport master (
    output bit_en, waveform,
    input  byte_out, byte_valid, word_idx, locked, frame_done, err_count
  );

  modport slave (
    input  bit_en, waveform,
    output byte_out, byte_valid, word_idx, locked, frame_done, err_count
  );

endinterface

// File: rtl/wave_shift_window.sv
// LSB-first shift register: each enabled cycle the new bit enters at the top,
// so after WIDTH shifts the first bit received sits in bit 0.
//   clk    : clock
//   clear  : synchronous active-high clear (wins over en)
//   en     : shift enable
//   din    : serial input bit
//   q      : current window
//   q_next : window value after a shift with the present din (for look-ahead compare)
module wave_shift_window #(
  parameter int WIDTH = wave_deserializer_pkg::WD_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  assign q_next = {din, q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/wave_deserializer.sv
// Reassembles the generator's serial waveform into words, finds frame
// alignment on the sync word, checks each word against the alternating
// even/odd pattern and reports lock, word index, frame completion and errors.
//   clk   : clock, all state on posedge
//   clear : synchronous active-high reset
//   bus   : slave side of wave_deserializer_if
//
// state  | meaning
// HUNT   | sliding the window one bit at a time looking for EVEN_WORD
// LOCKED | word-aligned; emitting and checking one word every WIDTH bits
module wave_deserializer
  import wave_deserializer_pkg::*;
#(
  parameter int               WIDTH      = WD_WIDTH,
  parameter int               DEPTH      = WD_DEPTH,
  parameter logic [WIDTH-1:0] EVEN_WORD  = WD_EVEN_WORD,
  parameter logic [WIDTH-1:0] ODD_WORD   = WD_ODD_WORD,
  parameter int               MISS_LIMIT = WD_MISS_LIMIT
) (
  input  logic                clk,
  input  logic                clear,
  wave_deserializer_if.slave  bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BIT_W  = $clog2(WIDTH);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  wd_state_t         state, state_next;
  logic [WIDTH-1:0]  window, window_next;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
  logic [MISS_W-1:0] miss_cnt, miss_cnt_next;
  logic [IDX_W-1:0]  idx_inc, emit_idx;
  logic [WIDTH-1:0]  expected;
  logic              sync_hit, word_done, mismatch;
  logic              emit, acquire, err_inc;

  wave_shift_window #(.WIDTH(WIDTH)) u_window (
    .clk    (clk),
    .clear  (clear),
    .en     (bus.bit_en),
    .din    (bus.waveform),
    .q      (window),
    .q_next (window_next)
  );

  // Compare against the window as it will be after this bit, so the word is
  // recognised on the same edge that samples its last bit.
  assign sync_hit  = bus.bit_en && (window_next == EVEN_WORD);
  assign word_done = bus.bit_en && (bit_cnt == BIT_W'(WIDTH - 1));
  assign idx_inc   = (bus.word_idx == IDX_W'(DEPTH - 1)) ? '0 : bus.word_idx + IDX_W'(1);
  assign expected  = idx_inc[0] ? ODD_WORD : EVEN_WORD;
  assign mismatch  = (window_next != expected);

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT: begin
        if (sync_hit) state_next = LOCKED;
      end
      LOCKED: begin
        if (word_done && mismatch && (miss_cnt == MISS_W'(MISS_LIMIT - 1))) begin
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    emit          = 1'b0;
    acquire       = 1'b0;
    err_inc       = 1'b0;
    emit_idx      = bus.word_idx;
    bit_cnt_next  = bit_cnt;
    miss_cnt_next = miss_cnt;
    case (state)
      HUNT: begin
        if (sync_hit) begin
          emit          = 1'b1;
          acquire       = 1'b1;
          emit_idx      = '0;
          bit_cnt_next  = '0;
          miss_cnt_next = '0;
        end
      end
      LOCKED: begin
        if (word_done) begin
          emit         = 1'b1;
          emit_idx     = idx_inc;
          bit_cnt_next = '0;
          if (mismatch) begin
            err_inc       = 1'b1;
            miss_cnt_next = miss_cnt + MISS_W'(1);
          end else begin
            miss_cnt_next = '0;
          end
        end else if (bus.bit_en) begin
          bit_cnt_next = bit_cnt + BIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bit_cnt        <= '0;
      miss_cnt       <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.word_idx   <= '0;
      bus.locked     <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_count  <= '0;
    end else begin
      bit_cnt        <= bit_cnt_next;
      miss_cnt       <= miss_cnt_next;
      bus.byte_valid <= emit;
      bus.frame_done <= emit && (emit_idx == IDX_W'(DEPTH - 1));
      if (emit) begin
        bus.byte_out <= window_next;
        bus.word_idx <= emit_idx;
      end
      if (err_inc && (bus.err_count != 8'hFF)) begin
        bus.err_count <= bus.err_count + 8'd1;
      end
      // Follows the state one cycle late so that locked is still high while
      // the word that broke lock is being presented.
      bus.locked <= acquire || (state == LOCKED);
    end
  end

endmodule

// File: tb/tb_wave_deserializer.sv
// Self-checking bench for wave_deserializer: a bit-level behavioural model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_wave_deserializer;

  logic clk = 1'b0;
  logic clear;

  wave_deserializer_if bus ();

  wave_deserializer dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;
  bit gap_mode = 1'b0;
  int fd_count = 0;
  int bv_times[$];

  // model state
  logic [7:0] m_win     = '0;
  bit         m_locked  = 1'b0;
  int         m_bits    = 0;
  int         m_miss    = 0;
  logic [7:0] exp_bo    = '0;
  bit         exp_bv    = 1'b0;
  int         exp_idx   = 0;
  bit         exp_lock  = 1'b0;
  bit         exp_fd    = 1'b0;
  int         exp_err   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_emit(input logic [7:0] w, input int idx);
    exp_bv  = 1'b1;
    exp_bo  = w;
    exp_idx = idx;
    exp_fd  = (idx == 15);
  endtask

  always @(posedge clk) begin
    cyc++;
    exp_bv = 1'b0;
    exp_fd = 1'b0;
    if (clear) begin
      m_win = '0; m_locked = 1'b0; m_bits = 0; m_miss = 0;
      exp_bo = '0; exp_idx = 0; exp_lock = 1'b0; exp_err = 0;
    end else begin
      exp_lock = m_locked;
      if (bus.bit_en) begin
        m_win = {bus.waveform, m_win[7:1]};
        if (!m_locked) begin
          if (m_win == 8'hCC) begin
            m_locked = 1'b1; exp_lock = 1'b1; m_bits = 0; m_miss = 0;
            model_emit(8'hCC, 0);
          end
        end else begin
          m_bits++;
          if (m_bits == 8) begin
            int idx;
            m_bits = 0;
            idx = (exp_idx + 1) % 16;
            model_emit(m_win, idx);
            if (m_win != ((idx % 2 == 1) ? 8'hAA : 8'hCC)) begin
              if (exp_err < 255) exp_err++;
              m_miss++;
              if (m_miss >= 2) m_locked = 1'b0;
            end else begin
              m_miss = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("byte_valid", {31'b0, bus.byte_valid}, {31'b0, exp_bv});
      check("frame_done", {31'b0, bus.frame_done}, {31'b0, exp_fd});
      check("locked",     {31'b0, bus.locked},     {31'b0, exp_lock});
      check("err_count",  {24'b0, bus.err_count},  exp_err);
      check("byte_out",   {24'b0, bus.byte_out},   {24'b0, exp_bo});
      check("word_idx",   {28'b0, bus.word_idx},   exp_idx);
      if (bus.frame_done) fd_count++;
      if (gap_mode && bus.byte_valid) bv_times.push_back(cyc);
    end
  end

  task automatic drive(input logic clr, input logic en, input logic w);
    clear        = clr;
    bus.bit_en   = en;
    bus.waveform = w;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input bit gap);
    for (int i = lo; i <= hi; i++) begin
      drive(1'b0, 1'b1, w[i]);
      if (gap) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input bit gap);
    send_bits(w, 0, 7, gap);
  endtask

  task automatic do_clear();
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    clear        = 1'b1;
    bus.bit_en   = 1'b0;
    bus.waveform = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    check("rst_locked", {31'b0, bus.locked}, 0);
    check("rst_err",    {24'b0, bus.err_count}, 0);
    check("rst_byte",   {24'b0, bus.byte_out}, 0);

    // clean stream: lock on first CC, two full frames
    do_clear();
    send_word(8'hCC, 1'b0);
    check("lock_bv",   {31'b0, bus.byte_valid}, 1);
    check("lock_byte", {24'b0, bus.byte_out}, 32'hCC);
    check("lock_idx",  {28'b0, bus.word_idx}, 0);
    check("lock_lock", {31'b0, bus.locked}, 1);
    fd_count = 0;
    for (int i = 1; i <= 32; i++) send_word((i % 2 == 1) ? 8'hAA : 8'hCC, 1'b0);
    check("frames", fd_count, 2);
    check("clean_err", {24'b0, bus.err_count}, 0);

    // single flipped bit in word 3
    send_word(8'hAA, 1'b0);
    send_word(8'hCC, 1'b0);
    send_word(8'hAB, 1'b0);
    check("flip_byte", {24'b0, bus.byte_out}, 32'hAB);
    check("flip_err",  {24'b0, bus.err_count}, 1);
    check("flip_lock", {31'b0, bus.locked}, 1);
    for (int i = 4; i <= 7; i++) send_word((i % 2 == 1) ? 8'hAA : 8'hCC, 1'b0);
    check("flip_err2",  {24'b0, bus.err_count}, 1);
    check("flip_lock2", {31'b0, bus.locked}, 1);

    // two consecutive bad words lose lock, relock on next CC
    do_clear();
    send_word(8'hCC, 1'b0);
    send_word(8'hAA, 1'b0);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("loss_bv",   {31'b0, bus.byte_valid}, 1);
    check("loss_lock", {31'b0, bus.locked}, 1);
    check("loss_err",  {24'b0, bus.err_count}, 2);
    send_bits(8'hAA, 0, 0, 1'b0);
    check("loss_unlock", {31'b0, bus.locked}, 0);
    send_bits(8'hAA, 1, 7, 1'b0);
    check("hunt_nolock", {31'b0, bus.locked}, 0);
    send_word(8'hCC, 1'b0);
    check("relock_bv",  {31'b0, bus.byte_valid}, 1);
    check("relock_idx", {28'b0, bus.word_idx}, 0);
    check("relock",     {31'b0, bus.locked}, 1);

    // bit_en toggling: same bytes, 16-cycle spacing
    do_clear();
    bv_times.delete();
    gap_mode = 1'b1;
    send_word(8'hCC, 1'b1);
    send_word(8'hAA, 1'b1);
    send_word(8'hCC, 1'b1);
    send_word(8'hAA, 1'b1);
    gap_mode = 1'b0;
    check("gap_pulses", bv_times.size(), 4);
    if (bv_times.size() == 4) begin
      for (int i = 1; i < 4; i++) check("gap_spacing", bv_times[i] - bv_times[i-1], 16);
    end
    check("gap_byte", {24'b0, bus.byte_out}, 32'hAA);
    check("gap_idx",  {28'b0, bus.word_idx}, 3);

    // clear at bit 5 of word 7
    do_clear();
    send_word(8'hCC, 1'b0);
    for (int i = 1; i <= 6; i++) send_word((i % 2 == 1) ? 8'hAA : 8'hCC, 1'b0);
    send_bits(8'hAA, 0, 4, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    check("mid_bv",   {31'b0, bus.byte_valid}, 0);
    check("mid_byte", {24'b0, bus.byte_out}, 0);
    check("mid_idx",  {28'b0, bus.word_idx}, 0);
    check("mid_lock", {31'b0, bus.locked}, 0);
    send_bits(8'hAA, 6, 7, 1'b0);
    send_word(8'hAA, 1'b0);
    check("mid_nolock", {31'b0, bus.locked}, 0);
    send_word(8'hCC, 1'b0);
    check("mid_relock", {31'b0, bus.locked}, 1);
    check("mid_reidx",  {28'b0, bus.word_idx}, 0);

    // error counter saturation across repeated relocks
    do_clear();
    for (int k = 0; k < 130; k++) begin
      send_word(8'hCC, 1'b0);
      send_word(8'h00, 1'b0);
      send_word(8'h00, 1'b0);
    end
    check("sat_err", {24'b0, bus.err_count}, 32'hFF);
    drive(1'b0, 1'b0, 1'b0);
    check("sat_unlock", {31'b0, bus.locked}, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
